// File: rtl/generic_sram_pkg.sv
// Shared definitions for the generic SRAM with byte enables and clear sweep:
// clear-sequencer state encoding and lane-geometry helpers.
package generic_sram_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      READY = 2'd2
   } clr_state_t;

   // Number of write-enable lanes in one data word.
   function automatic int calc_nbytes(input int dbits, input int bbits);
      return dbits / bbits;
   endfunction

   // The data word must split into whole lanes.
   function automatic bit lanes_ok(input int dbits, input int bbits);
      return (bbits > 0) && ((dbits % bbits) == 0);
   endfunction

endpackage

// File: rtl/generic_sram_clr_seq.sv
// Clear sequencer: walks every address once, writing zero, after reset
// (optionally) or on a single-cycle clear request while READY.
module generic_sram_clr_seq
   import generic_sram_pkg::*;
#(
   parameter int abits         = 10,
   parameter bit init_on_reset = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_req,
   output logic             busy,
   output logic [abits-1:0] clr_addr,
   output logic             clr_we,
   output clr_state_t       state
);

   // One extra bit so the terminal compare never sees a wrapped value.
   localparam logic [abits:0] last_addr = (abits+1)'((2**abits) - 1);

   clr_state_t     state_nx;
   logic [abits:0] cnt;
   logic [abits:0] cnt_nx;

   // State and sweep counter registers; reset always restarts at address 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= init_on_reset ? CLEAR : READY;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   // Next-state and counter logic; clr_req is only honoured in READY.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      case (state)
         IDLE: begin
            state_nx = init_on_reset ? CLEAR : READY;
            cnt_nx   = '0;
         end
         CLEAR: begin
            if (cnt == last_addr) begin
               state_nx = READY;
               cnt_nx   = '0;
            end else begin
               cnt_nx = cnt + (abits+1)'(1);
            end
         end
         READY: begin
            if (clr_req) begin
               state_nx = CLEAR;
               cnt_nx   = '0;
            end
         end
         default: begin
            state_nx = READY;
            cnt_nx   = '0;
         end
      endcase
   end

   assign busy     = (state == CLEAR);
   assign clr_we   = (state == CLEAR);
   assign clr_addr = cnt[abits-1:0];

endmodule

// File: rtl/generic_sram_be_clr.sv
// Dual-port synchronous SRAM model with per-lane write enables, selectable
// same-port read-during-write, optional output register and a zero-fill sweep.
module generic_sram_be_clr
   import generic_sram_pkg::*;
#(
   parameter int abits          = 10,
   parameter int dbits          = 16,
   parameter int bbits          = 8,
   parameter bit outreg         = 1'b0,
   parameter bit rdw_new        = 1'b0,
   parameter bit init_on_reset  = 1'b1,
   localparam int nbytes        = calc_nbytes(dbits, bbits)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [abits-1:0]  a0,
   input  logic [abits-1:0]  a1,
   input  logic [dbits-1:0]  d0,
   input  logic [dbits-1:0]  d1,
   input  logic              we0,
   input  logic              we1,
   input  logic [nbytes-1:0] be0,
   input  logic [nbytes-1:0] be1,
   input  logic              clr_req,
   output logic [dbits-1:0]  q0,
   output logic [dbits-1:0]  q1,
   output logic              busy
);

   localparam int depth = 2**abits;

   if (!lanes_ok(dbits, bbits)) begin : g_bad_lanes
      $error("generic_sram_be_clr: dbits must be a multiple of bbits");
   end

   logic [dbits-1:0] mem [depth];

   logic             clr_we;
   logic [abits-1:0] clr_addr;
   clr_state_t       clr_state;
   logic             port_en;

   logic [dbits-1:0] rd0_merged;
   logic [dbits-1:0] rd1_merged;
   logic [dbits-1:0] q0_rd;
   logic [dbits-1:0] q1_rd;

   generic_sram_clr_seq #(
      .abits         (abits),
      .init_on_reset (init_on_reset)
   ) u_clr_seq (
      .clk      (clk),
      .rst      (rst),
      .clr_req  (clr_req),
      .busy     (busy),
      .clr_addr (clr_addr),
      .clr_we   (clr_we),
      .state    (clr_state)
   );

   // Ports are frozen for the whole sweep.
   assign port_en = (clr_state != CLEAR);

   // Same-port merged view: old word with this port's enabled lanes replaced.
   always_comb begin
      rd0_merged = mem[a0];
      rd1_merged = mem[a1];
      for (int i = 0; i < nbytes; i++) begin
         if (we0 && be0[i]) rd0_merged[i*bbits +: bbits] = d0[i*bbits +: bbits];
         if (we1 && be1[i]) rd1_merged[i*bbits +: bbits] = d1[i*bbits +: bbits];
      end
   end

   // Array writes; port 1 is assigned last so it wins on shared lanes.
   always_ff @(posedge clk) begin
      if (clr_we) begin
         mem[clr_addr] <= '0;
      end else if (port_en) begin
         for (int i = 0; i < nbytes; i++) begin
            if (we0 && be0[i]) mem[a0][i*bbits +: bbits] <= d0[i*bbits +: bbits];
            if (we1 && be1[i]) mem[a1][i*bbits +: bbits] <= d1[i*bbits +: bbits];
         end
      end
   end

   // Read stage; cross-port reads always see the pre-write array contents.
   always_ff @(posedge clk) begin
      if (rst) begin
         q0_rd <= '0;
         q1_rd <= '0;
      end else if (port_en) begin
         q0_rd <= rdw_new ? rd0_merged : mem[a0];
         q1_rd <= rdw_new ? rd1_merged : mem[a1];
      end
   end

   if (outreg) begin : g_outreg
      logic [dbits-1:0] q0_pipe;
      logic [dbits-1:0] q1_pipe;

      // Output register stage; holds together with the read stage while busy.
      always_ff @(posedge clk) begin
         if (rst) begin
            q0_pipe <= '0;
            q1_pipe <= '0;
         end else if (port_en) begin
            q0_pipe <= q0_rd;
            q1_pipe <= q1_rd;
         end
      end

      assign q0 = q0_pipe;
      assign q1 = q1_pipe;
   end else begin : g_direct
      assign q0 = q0_rd;
      assign q1 = q1_rd;
   end

endmodule

// File: doc/generic_sram_be_clr.md
# generic_sram_be_clr

Parametrised dual-port synchronous SRAM model for tech-independent and simulation builds, succeeding the plain two-port generic SRAM. It adds per-byte write enables, an optional output pipeline register, selectable same-port read-during-write behaviour, and a built-in clear sequencer that zero-fills the array after reset or on request. It sits under the techmap memory wrappers wherever a tech macro is unavailable.

## Interface
- abits, 10, address width; depth = 2**abits
- dbits, 16, data width; must be a multiple of bbits
- bbits, 8, bits per write-enable lane; nbytes = dbits/bbits
- outreg, 0, 1 adds one output register stage (read latency 2 instead of 1)
- rdw_new, 0, same-port read-during-write: 0 returns old data, 1 returns merged new data
- init_on_reset, 1, 1 runs the clear sweep after reset
- Clocking: one clock; reset is synchronous and active-high.
- clk  in  1  clock; all state changes on posedge
- rst  in  1  synchronous active-high reset
- a0, a1  in  abits  port 0/1 address
- d0, d1  in  dbits  port 0/1 write data
- we0, we1  in  1  port 0/1 write enable
- be0, be1  in  nbytes  port 0/1 byte-lane enables, qualified by weN
- clr_req  in  1  single-cycle request to zero the array
- q0, q1  out  dbits  port 0/1 read data
- busy  out  1  clear sweep in progress; port accesses ignored

## Operation
- Both ports read every cycle when not busy; a port writes lane i iff weN and beN[i].
- Same-port read-during-write: rdw_new=0 gives pre-write word; rdw_new=1 gives pre-write word with enabled lanes replaced by dN.
- Cross-port: a read always returns the pre-write word, even if the other port writes that address in the same cycle.
- Write collision on the same address: port 1 wins on overlapping enabled lanes; non-overlapping lanes from both ports are written.
- Clear FSM states are IDLE, CLEAR, and READY.
  - rst -> CLEAR if init_on_reset, else READY.
  - CLEAR: a counter writes 0 to address cnt each cycle, starting at 0. After writing depth-1 it goes to READY.
  - READY + clr_req -> CLEAR with cnt=0. Port accesses in the clr_req cycle are still performed.
  - clr_req while in CLEAR is ignored; the sweep does not restart.
- busy = (state == CLEAR). While busy, weN is ignored and q0/q1 hold their last value.

## Timing
- Reset values: q0=q1=0 and the output pipeline registers are 0. busy=1 the cycle after rst is sampled if init_on_reset, else 0. Array contents are not reset directly.
- Sweep: starts in the first cycle after rst deasserts. busy stays high for exactly 2**abits cycles after rst drops.
- An rst mid-sweep restarts the sweep from address 0.
- After clr_req in READY: busy rises next cycle and is high for 2**abits cycles.
- Read latency: address in cycle N gives data on q in cycle N+1 (outreg=0) or N+2 (outreg=1).
- Output stage with outreg=1: advances every cycle when not busy and holds while busy.
- No backpressure: one access per port per cycle, fully pipelined.
- Widths: counter is abits+1 bits so the terminal compare does not wrap. A byte-enable lane i covers bits [i*bbits +: bbits].

## Structure
- Package generic_sram_pkg: clear-FSM state encoding (IDLE/CLEAR/READY), nbytes helper function, and the elaboration check dbits % bbits == 0.
- Sub-module generic_sram_clr_seq: FSM plus counter, producing busy, clear address, and clear write strobe.
- The top level holds the array, lane-merge logic, the collision rule, and the optional output stage.

## Test plan
- Reset sweep with abits=4, init_on_reset=1: preload via backdoor, then pulse rst. Required: busy high for exactly 16 cycles, then reads of all addresses return 0.
- Byte enables with dbits=32: write 0xAABBCCDD to addr 3 with be=4'b1111, then 0x11223344 with be=4'b0101. Required: read of addr 3 returns 0xAA22CC44 one cycle later (outreg=0).
- Read-during-write on addr 5 holding 0x1234, port 0 writes 0xBEEF with full be while reading. Required: rdw_new=0 returns 0x1234, rdw_new=1 returns 0xBEEF. A port 1 read of addr 5 in the same cycle returns 0x1234.
- Collision: both ports write addr 7, port 0 data 0x00FF with be=11, port 1 data 0xAB00 with be=10. Required: addr 7 reads 0xABFF.
- Latency with outreg=1: addresses 0,1,2 on consecutive cycles. Required: data appears at N+2, N+3, N+4 with no bubbles.
- Clear request in READY with writes pending: pulse clr_req, assert we0 during busy, and pulse clr_req again mid-sweep. Required: writes during busy are dropped, busy lasts exactly 2**abits cycles without restart, and all words read 0 afterward. rst mid-sweep restarts the sweep at 0.
